ysyx_23060077_wb_sched: RTL and testbench
=========================================

# ysyx_23060077_wb_sched

Write-back scheduler and scoreboard for the integer register file. It arbitrates between two write-back requesters, the execute unit (EXU) and the load/store unit (LSU), for the register file's single write port, and drives that port from a registered stage. It also tracks outstanding writes per architectural register so that decode can stall on read-after-write hazards. It sits between the EXU/LSU outputs, the decode/issue stage and the register file's rd_en/rd_addr/rd_data inputs.

## Interface
- DATA_WIDTH, 32, width of register data
- REG_WIDTH, 5, register address width
- REG_COUNT, 32, number of architectural registers
- CNT_WIDTH, 2, width of the per-register pending-write counter (max 2^CNT_WIDTH-1 outstanding)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- exu_wb_valid  in  1  EXU write-back request
- exu_wb_ready  out  1  EXU request accepted this cycle
- exu_wb_rd  in  REG_WIDTH  EXU destination register
- exu_wb_data  in  DATA_WIDTH  EXU result
- lsu_wb_valid  in  1  LSU write-back request
- lsu_wb_ready  out  1  LSU request accepted this cycle
- lsu_wb_rd  in  REG_WIDTH  LSU destination register
- lsu_wb_data  in  DATA_WIDTH  LSU load data
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_ready  out  1  scoreboard can record the issue
- issue_rd  in  REG_WIDTH  destination of the issuing instruction
- rs1_addr, rs2_addr  in  REG_WIDTH  source registers being decoded
- rs1_busy, rs2_busy  out  1  source register has a pending write
- rd_en  out  1  register-file write enable
- rd_addr  out  REG_WIDTH  register-file write address
- rd_data  out  DATA_WIDTH  register-file write data
- idle  out  1  no pending counts and no write in the output stage

## Operation
- Arbitration: a single grant per cycle. If only one requester is valid, it is granted. If both are valid, round-robin applies: the requester not granted most recently wins. last_grant resets to LSU, so EXU wins the first tie.
- exu_wb_ready and lsu_wb_ready are combinational from the valids and last_grant. At most one of them is high. A transfer occurs on valid & ready. last_grant updates only on a transfer.
- Output stage: an accepted request is registered into rd_en/rd_addr/rd_data at the next edge. rd_en = 1 only if the accepted rd != 0. With no transfer, rd_en = 0 and rd_addr/rd_data hold their values.
- Scoreboard: REG_COUNT counters of CNT_WIDTH bits. Counter 0 is hardwired to 0.
  - Increment on issue_valid & issue_ready with issue_rd != 0.
  - Decrement at the edge where the output stage holds rd_en = 1 for that address, i.e. the same edge at which the register file captures the data.
  - If an increment and a decrement hit the same register at the same edge, the counter is unchanged.
  - A decrement of a zero counter is a protocol error. The counter stays at 0 (no underflow) and the write still proceeds.
- issue_ready = 1 if issue_rd == 0 or the current count < max. It is based on the current count only, even if a decrement lands the same cycle.
- rs1_busy/rs2_busy = (count[addr] != 0), combinational. Address 0 is never busy.
- Writes to x0: the request is accepted and consumes the grant, but rd_en stays 0 and no counter changes.
- idle = all counters zero & ~rd_en.

## Timing
- Reset (asserted low, asynchronous): rd_en = 0, rd_addr = 0, rd_data = 0, all counters = 0, last_grant = LSU. Resulting outputs: idle = 1, issue_ready = 1, rs*_busy = 0.
- Reset mid-operation discards in-flight writes and counts. Requesters must re-present after deassertion.
- Accept-to-write latency is 1 cycle: a transfer at edge N gives rd_en = 1 during cycle N+1, and the register file writes at edge N+1.
- Issue-to-busy latency is 1 cycle: an issue at edge N makes busy visible after edge N.
- Busy clears after the edge that writes the register file, so a read in the following cycle sees the new data.
- Sustained throughput is one write-back per cycle. With both requesters continuously valid, grants alternate EXU, LSU, EXU, ...

## Test plan
- Reset, then issue rd = 5 and EXU write-back rd = 5, data 0x1234 two cycles later -> rs1_busy (rs1_addr = 5) is 1 from the cycle after issue until the cycle after the rd_en pulse. The rd_en pulse has rd_addr = 5 and rd_data = 0x1234, exactly 1 cycle after exu_wb_ready.
- EXU and LSU both valid for 4 cycles (rd = 1..4 / 6..9) -> ready pattern EXU, LSU, EXU, LSU. The rd_en stream carries addresses 1, 6, 2, 7, with no lost or duplicated writes.
- Issue rd = 3 three times (CNT_WIDTH = 2) -> issue_ready = 0 for a fourth issue to rd = 3 while issue_ready = 1 for rd = 4. After one write-back to rd = 3 completes, issue_ready for rd = 3 returns to 1.
- Issue rd = 8 in the same cycle that the output stage writes rd = 8 with count 1 -> count stays 1 and rs1_busy for 8 stays 1.
- LSU write-back to rd = 0 with data 0xFFFF_FFFF -> lsu_wb_ready = 1, rd_en stays 0, and idle stays 1.
- Assert reset low asynchronously while rd_en = 1 and counts are nonzero -> rd_en drops immediately, all busy = 0, idle = 1, and after release the first tie is granted to EXU.

Source files
------------

// File: rtl/ysyx_23060077_wb_sched.sv
// Write-back scheduler: round-robin EXU/LSU arbitration onto the single register-file
// write port, plus a per-register pending-write scoreboard for decode hazard stalls.
module ysyx_23060077_wb_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int REG_COUNT  = 32,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exu_wb_valid,
  output logic                  exu_wb_ready,
  input  logic [REG_WIDTH-1:0]  exu_wb_rd,
  input  logic [DATA_WIDTH-1:0] exu_wb_data,
  input  logic                  lsu_wb_valid,
  output logic                  lsu_wb_ready,
  input  logic [REG_WIDTH-1:0]  lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0] lsu_wb_data,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_WIDTH-1:0]  issue_rd,
  input  logic [REG_WIDTH-1:0]  rs1_addr,
  input  logic [REG_WIDTH-1:0]  rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_en,
  output logic [REG_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  idle
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [REG_WIDTH-1:0]  REG_ZERO = {REG_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DAT_ZERO = {DATA_WIDTH{1'b0}};

  // last_lsu_r = 1 means the LSU won the most recent transfer
  logic                  last_lsu_r;
  logic [CNT_WIDTH-1:0]  cnt_r     [REG_COUNT];
  logic [CNT_WIDTH-1:0]  cnt_nxt_s [REG_COUNT];
  logic                  xfer_s;
  logic                  issue_fire_s;
  logic                  any_pending_s;
  logic [REG_WIDTH-1:0]  sel_rd_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  assign exu_wb_ready = exu_wb_valid & (~lsu_wb_valid | last_lsu_r);
  assign lsu_wb_ready = lsu_wb_valid & (~exu_wb_valid | ~last_lsu_r);
  assign xfer_s       = exu_wb_ready | lsu_wb_ready;
  assign sel_rd_s     = lsu_wb_ready ? lsu_wb_rd   : exu_wb_rd;
  assign sel_data_s   = lsu_wb_ready ? lsu_wb_data : exu_wb_data;

  assign issue_ready  = (issue_rd == REG_ZERO) | (cnt_r[issue_rd] != CNT_MAX);
  assign issue_fire_s = issue_valid & issue_ready;
  assign rs1_busy     = (cnt_r[rs1_addr] != CNT_ZERO);
  assign rs2_busy     = (cnt_r[rs2_addr] != CNT_ZERO);
  assign idle         = ~any_pending_s & ~rd_en;

  // Per-register counter update; a coincident increment and decrement cancel out
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (i == 0) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (issue_fire_s && (issue_rd == REG_WIDTH'(i)) &&
                   !(rd_en && (rd_addr == REG_WIDTH'(i)))) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end else if (rd_en && (rd_addr == REG_WIDTH'(i)) &&
                   !(issue_fire_s && (issue_rd == REG_WIDTH'(i))) &&
                   (cnt_r[i] != CNT_ZERO)) begin
        cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Reduce the counters into a single "something outstanding" flag
  always_comb begin
    any_pending_s = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      any_pending_s = any_pending_s | (cnt_r[i] != CNT_ZERO);
    end
  end

  // Scoreboard counter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Round-robin pointer and registered write port; x0 writes are swallowed here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_lsu_r <= 1'b1;
      rd_en      <= 1'b0;
      rd_addr    <= REG_ZERO;
      rd_data    <= DAT_ZERO;
    end else if (xfer_s) begin
      last_lsu_r <= lsu_wb_ready;
      rd_en      <= (sel_rd_s != REG_ZERO);
      rd_addr    <= sel_rd_s;
      rd_data    <= sel_data_s;
    end else begin
      last_lsu_r <= last_lsu_r;
      rd_en      <= 1'b0;
      rd_addr    <= rd_addr;
      rd_data    <= rd_data;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_wb_sched.sv
// Self-checking bench for ysyx_23060077_wb_sched: a grant model predicts readies and
// pushes expected register-file writes, which a monitor pops on every rd_en pulse.
module tb_ysyx_23060077_wb_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exu_wb_valid = 1'b0, lsu_wb_valid = 1'b0;
  logic        exu_wb_ready, lsu_wb_ready;
  logic [4:0]  exu_wb_rd = 5'd0, lsu_wb_rd = 5'd0;
  logic [31:0] exu_wb_data = 32'd0, lsu_wb_data = 32'd0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [4:0]  issue_rd = 5'd0, rs1_addr = 5'd0, rs2_addr = 5'd0;
  logic        rs1_busy, rs2_busy;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        idle;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_exp;
  int  checks = 0;
  int  errors = 0;
  bit  last_lsu = 1'b1;

  ysyx_23060077_wb_sched dut (
    .clk(clk), .reset(reset),
    .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready),
    .exu_wb_rd(exu_wb_rd), .exu_wb_data(exu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .idle(idle)
  );

  always #5 clk = ~clk;

  // Every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (reset && rd_en) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got write addr=%0d data=%h, required none", rd_addr, rd_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (rd_addr !== mon_exp.a || rd_data !== mon_exp.d) begin
          errors++;
          $display("FAIL wb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rd_addr, rd_data, mon_exp.a, mon_exp.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present requests for one cycle, check readies against the model, record the winner
  task automatic wb_cycle(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                          output logic got_exu, output logic got_lsu);
    logic exp_e, exp_l;
    exu_wb_valid = ev; exu_wb_rd = erd; exu_wb_data = ed;
    lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ld;
    #1;
    exp_e = ev && (!lv || last_lsu);
    exp_l = lv && (!ev || !last_lsu);
    checks++;
    if (exu_wb_ready !== exp_e || lsu_wb_ready !== exp_l) begin
      errors++;
      $display("FAIL ready: got exu=%b lsu=%b, required exu=%b lsu=%b",
               exu_wb_ready, lsu_wb_ready, exp_e, exp_l);
    end
    if (exp_e) begin
      if (erd != 5'd0) sb_q.push_back('{a: erd, d: ed});
      last_lsu = 1'b0;
    end else if (exp_l) begin
      if (lrd != 5'd0) sb_q.push_back('{a: lrd, d: ld});
      last_lsu = 1'b1;
    end
    got_exu = exp_e;
    got_lsu = exp_l;
    step();
    exu_wb_valid = 1'b0;
    lsu_wb_valid = 1'b0;
  endtask

  task automatic issue_one(input logic [4:0] r);
    issue_valid = 1'b1; issue_rd = r;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rd_en !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: got en=%b addr=%0d data=%h, required 0/0/0", rd_en, rd_addr, rd_data);
    end
    checks++;
    if (idle !== 1'b1 || issue_ready !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got idle=%b ir=%b b1=%b b2=%b, required 1/1/0/0",
               idle, issue_ready, rs1_busy, rs2_busy);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    logic ge, gl;
    int ei = 1, li = 6;
    logic [3:0] pat;
    for (int c = 0; c < 4; c++) begin
      wb_cycle(1'b1, 5'(ei), 32'h100 + 32'(ei), 1'b1, 5'(li), 32'h200 + 32'(li), ge, gl);
      pat[c] = gl;
      if (ge) ei++;
      if (gl) li++;
    end
    step();
    checks++;
    if (pat !== 4'b1010) begin
      errors++;
      $display("FAIL rr_pattern: got lsu-grant bits %b (c3..c0), required 1010", pat);
    end
    checks++;
    if (sb_q.size() != 0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rr_drain: got %0d pending idle=%b, required 0 pending idle=1", sb_q.size(), idle);
    end
  endtask

  task automatic test_raw();
    logic ge, gl;
    rs1_addr = 5'd5;
    issue_one(5'd5);
    checks++;
    if (rs1_busy !== 1'b1 || idle !== 1'b0) begin
      errors++;
      $display("FAIL raw_busy_set: got busy=%b idle=%b, required 1/0", rs1_busy, idle);
    end
    step();
    wb_cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, ge, gl);
    checks++;
    if (rd_en !== 1'b1 || rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL raw_write_cycle: got rd_en=%b busy=%b, required 1/1", rd_en, rs1_busy);
    end
    step();
    checks++;
    if (rd_en !== 1'b0 || rs1_busy !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL raw_busy_clear: got rd_en=%b busy=%b idle=%b, required 0/0/1", rd_en, rs1_busy, idle);
    end
  endtask

  task automatic test_saturate();
    logic ge, gl;
    for (int k = 0; k < 3; k++) begin
      issue_rd = 5'd3;
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL sat_fill: issue %0d got ready=%b, required 1", k, issue_ready);
      end
      issue_one(5'd3);
    end
    issue_rd = 5'd3; #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_full: got ready=%b for rd3, required 0", issue_ready);
    end
    issue_rd = 5'd4; #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_other: got ready=%b for rd4, required 1", issue_ready);
    end
    wb_cycle(1'b1, 5'd3, 32'hC0DE_0003, 1'b0, 5'd0, 32'd0, ge, gl);
    issue_rd = 5'd3; #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_same_cycle: got ready=%b during write, required 0", issue_ready);
    end
    step();
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_release: got ready=%b, required 1", issue_ready);
    end
    wb_cycle(1'b1, 5'd3, 32'hC0DE_1003, 1'b0, 5'd0, 32'd0, ge, gl);
    wb_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hC0DE_2003, ge, gl);
    step();
    rs1_addr = 5'd3; #1;
    checks++;
    if (rs1_busy !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL sat_drain: got busy=%b idle=%b, required 0/1", rs1_busy, idle);
    end
  endtask

  task automatic test_same_edge();
    logic ge, gl;
    rs1_addr = 5'd8;
    issue_one(5'd8);
    wb_cycle(1'b1, 5'd8, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, ge, gl);
    issue_valid = 1'b1; issue_rd = 5'd8;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || rd_en !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_setup: got ready=%b rd_en=%b, required 1/1", issue_ready, rd_en);
    end
    step();
    issue_valid = 1'b0;
    checks++;
    if (rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_busy: got busy=%b, required 1", rs1_busy);
    end
    wb_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h0000_00BB, ge, gl);
    step();
    checks++;
    if (rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_drain: got busy=%b, required 0", rs1_busy);
    end
  endtask

  task automatic test_x0();
    logic ge, gl;
    wb_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, ge, gl);
    checks++;
    if (rd_en !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL x0_write: got rd_en=%b idle=%b, required 0/1", rd_en, idle);
    end
  endtask

  task automatic test_async_reset();
    logic ge, gl;
    rs1_addr = 5'd10;
    issue_one(5'd10);
    wb_cycle(1'b1, 5'd11, 32'h5555_0011, 1'b0, 5'd0, 32'd0, ge, gl);
    checks++;
    if (rd_en !== 1'b1 || rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup: got rd_en=%b busy=%b, required 1/1", rd_en, rs1_busy);
    end
    #1 reset = 1'b0;
    #1;
    sb_q.delete();
    last_lsu = 1'b1;
    checks++;
    if (rd_en !== 1'b0 || rs1_busy !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL arst_clear: got rd_en=%b busy=%b idle=%b, required 0/0/1", rd_en, rs1_busy, idle);
    end
    step();
    step();
    reset = 1'b1;
    step();
    wb_cycle(1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 5'd13, 32'h0000_0D0D, ge, gl);
    checks++;
    if (ge !== 1'b1) begin
      errors++;
      $display("FAIL arst_first_tie: got exu_grant=%b, required 1", ge);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_raw();
    test_saturate();
    test_same_edge();
    test_x0();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d writes never seen, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
